// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad and turns it into a 4-bit key code.
//   One column is driven low at a time. The rows are sampled once per column
//   slot, so a full frame covers all 16 switches. A frame is usable only when
//   exactly one switch reads closed. Frames with no switch, or with two or more
//   switches (ghosting / multi-key), are rejected. Usable frames are debounced
//   over DEBOUNCE_FRAMES frames before a press or a release is accepted.
//
//   RESET_N is expected to be released synchronously to CLOCK_50 by the
//   board-level reset logic; assertion is asynchronous.
//
// Parameters
//   SCAN_DIV         clock cycles per column slot (>= 4)
//   DEBOUNCE_FRAMES  identical consecutive frames needed to accept a press or
//                    a release (>= 1)
//
// Ports
//   CLOCK_50   in   1  system clock, rising edge
//   RESET_N    in   1  asynchronous active-low reset
//   KP_ROW     in   4  keypad rows, active-low, asynchronous to CLOCK_50
//   KP_COL     out  4  column drive, active-low one-hot, registered
//   KEY_CODE   out  4  last accepted key = {row_idx, col_idx}
//   KEY_VALID  out  1  one-cycle strobe per accepted press
//   KEY_HELD   out  1  high while the accepted key stays debounced-pressed
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KP_ROW,
  output logic [3:0] KP_COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_FRAMES);

  // Hit counts seen in a sample or accumulated over a frame; MANY saturates.
  localparam logic [1:0] HITS_NONE = 2'd0;
  localparam logic [1:0] HITS_ONE  = 2'd1;
  localparam logic [1:0] HITS_MANY = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchroniser
  //   KP_ROW is asynchronous; nothing downstream looks at it before two flops.
  //   The flops reset to all-ones, the idle (pulled-up) row level.
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  // NOTE: every clocked block uses non-blocking assignments, so each register
  // loads the value its source had before the edge; with blocking assignments
  // row_sync would pick up KP_ROW in the same edge and the second stage would
  // vanish.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= KP_ROW;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot timer and column drive
  //   tick marks the last cycle of a slot. The rows for the current column are
  //   sampled in that cycle, and the column advances on the same edge. KP_COL
  //   is registered alongside col so the pins change cleanly once per slot.
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col;
  logic [1:0]        col_next;
  logic              tick;
  logic              frame_end;

  assign tick      = (slot_cnt == SLOT_LAST);
  assign frame_end = tick && (col == 2'd3);
  assign col_next  = col + 2'd1;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_cnt <= '0;
      col      <= 2'd0;
      KP_COL   <= 4'b1110;
    end else if (tick) begin
      slot_cnt <= '0;
      col      <= col_next;
      KP_COL   <= ~(4'b0001 << col_next);
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sample classification and frame accumulation
  //   Each sample is reduced to NONE / ONE(row) / MANY. Samples fold into a
  //   running frame summary. Only the first key found is remembered, because
  //   a second hit anywhere in the frame makes the frame unusable anyway.
  //   frame_hits/frame_key include the sample being taken this cycle. At
  //   frame end they are the complete frame result.
  // ---------------------------------------------------------------------------
  logic [3:0] row_low;
  logic [1:0] sample_hits;
  logic [1:0] sample_row;
  logic [1:0] acc_hits;
  logic [3:0] acc_key;
  logic [1:0] frame_hits;
  logic [3:0] frame_key;
  logic       frame_single;

  // NOTE: each variable written in this block gets a default value before the
  // case, so every path assigns every output and no latch is inferred.
  always_comb begin
    row_low     = ~row_sync;
    sample_hits = HITS_MANY;
    sample_row  = 2'd0;
    case (row_low)
      4'b0000: sample_hits = HITS_NONE;
      4'b0001: begin sample_hits = HITS_ONE; sample_row = 2'd0; end
      4'b0010: begin sample_hits = HITS_ONE; sample_row = 2'd1; end
      4'b0100: begin sample_hits = HITS_ONE; sample_row = 2'd2; end
      4'b1000: begin sample_hits = HITS_ONE; sample_row = 2'd3; end
      default: sample_hits = HITS_MANY;
    endcase

    frame_hits = acc_hits;
    frame_key  = acc_key;
    if (sample_hits != HITS_NONE) begin
      if (acc_hits == HITS_NONE) begin
        frame_hits = sample_hits;
        frame_key  = {sample_row, col};
      end else begin
        frame_hits = HITS_MANY;
      end
    end

    frame_single = (frame_hits == HITS_ONE);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_hits <= HITS_NONE;
      acc_key  <= 4'd0;
    end else if (tick) begin
      if (col == 2'd3) begin
        // Column 3 closes the frame; the next frame starts from scratch.
        acc_hits <= HITS_NONE;
        acc_key  <= 4'd0;
      end else begin
        acc_hits <= frame_hits;
        acc_key  <= frame_key;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM and registered outputs
  //   The FSM moves only at frame end. cnt counts qualifying frames in
  //   DEBOUNCE and RELEASE and saturates at DEBOUNCE_FRAMES. The outputs are
  //   updated on the same edge as the state, so they appear one cycle after
  //   the frame-end tick.
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             same_key;

  always_comb begin
    cnt_inc  = (cnt == CNT_TARGET) ? cnt : cnt + CNT_W'(1);
    same_key = frame_single && (frame_key == cand);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      KEY_CODE  <= 4'd0;
      KEY_VALID <= 1'b0;
      KEY_HELD  <= 1'b0;
    end else begin
      KEY_VALID <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (frame_single) begin
              cand <= frame_key;
              cnt  <= CNT_W'(1);
              if (DEBOUNCE_FRAMES == 1) begin
                state     <= PRESSED;
                KEY_CODE  <= frame_key;
                KEY_VALID <= 1'b1;
                KEY_HELD  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end

          DEBOUNCE: begin
            if (same_key) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_TARGET) begin
                state     <= PRESSED;
                KEY_CODE  <= cand;
                KEY_VALID <= 1'b1;
                KEY_HELD  <= 1'b1;
              end
            end else if (frame_single) begin
              // A different single key restarts the count for that key.
              cand <= frame_key;
              cnt  <= CNT_W'(1);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end

          PRESSED: begin
            if (same_key) begin
              cnt <= '0;
            end else begin
              state <= RELEASE;
              cnt   <= CNT_W'(1);
            end
          end

          RELEASE: begin
            if (same_key) begin
              // Release glitch shorter than the debounce window: resume
              // silently, without a second strobe.
              state <= PRESSED;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_TARGET) begin
                state    <= IDLE;
                cnt      <= '0;
                KEY_HELD <= 1'b0;
              end
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_FRAMES=3, so one
//   frame is 16 cycles. A small keypad model turns the set of closed switches
//   into row levels from the driven columns. Stimulus changes only on frame
//   boundaries. Each frame checks the column walk, the absence of stray
//   strobes, and the outputs right after the frame-end edge.
//   Directed frames come from a table of expected values. Random frames are
//   checked against a window-based reference model.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DF       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  kp_row;
  logic [3:0]  kp_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;          // bit r*4+c = switch at row r, column c closed

  int checks   = 0;
  int errors   = 0;
  int frame_no = 0;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .KP_ROW    (kp_row),
    .KP_COL    (kp_col),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .KEY_HELD  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed switch pulls its row low while its column is driven.
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame with the given switch set, starting at a frame boundary.
  task automatic run_frame(input logic [15:0] k, input logic ev, input logic eh,
                           input logic [3:0] ec, input string tag);
    logic [3:0] col_exp;
    keys = k;
    frame_no++;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      col_exp = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      check($sformatf("%s f%0d kp_col c%0d", tag, frame_no, i), 32'(kp_col), 32'(col_exp));
      if (i < FRAME)
        check($sformatf("%s f%0d stray_valid c%0d", tag, frame_no, i), 32'(key_valid), 32'(0));
    end
    check($sformatf("%s f%0d key_valid", tag, frame_no), 32'(key_valid), 32'(ev));
    check($sformatf("%s f%0d key_held", tag, frame_no), 32'(key_held), 32'(eh));
    check($sformatf("%s f%0d key_code", tag, frame_no), 32'(key_code), 32'(ec));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " kp_col"},    32'(kp_col),    32'(4'b1110));
    check({tag, " key_code"},  32'(key_code),  32'(0));
    check({tag, " key_valid"}, 32'(key_valid), 32'(0));
    check({tag, " key_held"},  32'(key_held),  32'(0));
  endtask

  // Reset with no keys; released on a falling edge so the next rising edge
  // is cycle 1 of frame 1.
  task automatic do_reset(input string tag);
    keys  = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs(tag);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. A frame result is a single key when exactly one switch is
  // closed. A press is accepted when the last DF results since the previous
  // accept/release event are the same single key. A held key is released when
  // the last DF results since acceptance all differ from it.
  // ---------------------------------------------------------------------------
  logic       m_held;
  logic [3:0] m_code;
  int         hist[$];

  task automatic model_frame(input logic [15:0] k, output logic ev,
                             output logic eh, output logic [3:0] ec);
    int res;
    bit all_same;
    bit all_other;
    res = -1;
    if ($countones(k) == 1)
      for (int b = 0; b < 16; b++) if (k[b]) res = b;
    hist.push_back(res);
    if (hist.size() > DF) void'(hist.pop_front());
    ev = 1'b0;
    if (hist.size() == DF) begin
      all_same  = (hist[0] >= 0);
      all_other = 1'b1;
      for (int i = 0; i < DF; i++) begin
        if (hist[i] != hist[0]) all_same = 1'b0;
        if (hist[i] == int'(m_code)) all_other = 1'b0;
      end
      if (!m_held && all_same) begin
        m_held = 1'b1;
        m_code = 4'(hist[0]);
        ev     = 1'b1;
        hist.delete();
      end else if (m_held && all_other) begin
        m_held = 1'b0;
        hist.delete();
      end
    end
    eh = m_held;
    ec = m_code;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: one record per frame, expected values worked out by hand.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] keys;
    logic        valid;
    logic        held;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input logic [15:0] k, input int n, input logic v,
                       input logic h, input logic [3:0] c);
    vec_t e;
    e.keys = k; e.valid = v; e.held = h; e.code = c;
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endtask

  initial begin
    logic [15:0] cur;
    logic        ev;
    logic        eh;
    logic [3:0]  ec;
    int          r;
    int          a;
    int          b;

    // Key 9 held 20 frames: single strobe at frame 3, then clean release.
    add_n(16'h0200,  2, 0, 0, 4'd0);
    add_n(16'h0200,  1, 1, 1, 4'd9);
    add_n(16'h0200, 17, 0, 1, 4'd9);
    add_n(16'h0000,  2, 0, 1, 4'd9);
    add_n(16'h0000,  1, 0, 0, 4'd9);
    // Key 9 toggled every frame: never accepted.
    for (int i = 0; i < 4; i++) begin
      add_n(16'h0200, 1, 0, 0, 4'd9);
      add_n(16'h0000, 1, 0, 0, 4'd9);
    end
    // Keys 0 and 5 together, then key 5 lifted: key 0 accepted 3 frames later.
    add_n(16'h0021,  5, 0, 0, 4'd9);
    add_n(16'h0001,  2, 0, 0, 4'd9);
    add_n(16'h0001,  1, 1, 1, 4'd0);
    add_n(16'h0001,  1, 0, 1, 4'd0);
    add_n(16'h0000,  2, 0, 1, 4'd0);
    add_n(16'h0000,  1, 0, 0, 4'd0);
    // Key 9 accepted, one-frame release glitch, then clean release.
    add_n(16'h0200,  2, 0, 0, 4'd0);
    add_n(16'h0200,  1, 1, 1, 4'd9);
    add_n(16'h0000,  1, 0, 1, 4'd9);
    add_n(16'h0200,  2, 0, 1, 4'd9);
    add_n(16'h0000,  2, 0, 1, 4'd9);
    add_n(16'h0000,  2, 0, 0, 4'd9);
    // Different key while pressed: full release, then a fresh debounce.
    add_n(16'h0200,  2, 0, 0, 4'd9);
    add_n(16'h0200,  1, 1, 1, 4'd9);
    add_n(16'h0040,  2, 0, 1, 4'd9);
    add_n(16'h0040,  3, 0, 0, 4'd9);
    add_n(16'h0040,  1, 1, 1, 4'd6);
    add_n(16'h0000,  2, 0, 1, 4'd6);
    add_n(16'h0000,  1, 0, 0, 4'd6);
    // Two keys on one row, and two keys on one column: always rejected.
    add_n(16'h0300,  3, 0, 0, 4'd6);
    add_n(16'h0022,  3, 0, 0, 4'd6);

    do_reset("reset");
    for (int i = 0; i < vecs.size(); i++)
      run_frame(vecs[i].keys, vecs[i].valid, vecs[i].held, vecs[i].code, "dir");

    // Reset in the middle of debouncing key 12: no strobe. The count restarts
    // from the release of reset.
    run_frame(16'h1000, 0, 0, 4'd6, "rstmid");
    run_frame(16'h1000, 0, 0, 4'd6, "rstmid");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rstmid async");
    repeat (2) @(negedge clk);
    check_reset_outputs("rstmid held");
    rst_n = 1'b1;
    run_frame(16'h1000, 0, 0, 4'd0,  "rstmid");
    run_frame(16'h1000, 0, 0, 4'd0,  "rstmid");
    run_frame(16'h1000, 1, 1, 4'd12, "rstmid");
    run_frame(16'h1000, 0, 1, 4'd12, "rstmid");

    // Random frames against the reference model.
    do_reset("rand reset");
    m_held = 1'b0;
    m_code = 4'd0;
    hist.delete();
    cur = 16'h0000;
    for (int f = 0; f < 90; f++) begin
      r = int'($urandom_range(0, 9));
      if (r == 6) begin
        cur = 16'h0000;
      end else if (r == 7) begin
        cur = 16'h0001 << $urandom_range(0, 15);
      end else if (r == 8) begin
        a   = int'($urandom_range(0, 15));
        b   = (a + 1 + int'($urandom_range(0, 14))) % 16;
        cur = (16'h0001 << a) | (16'h0001 << b);
      end else if (r == 9) begin
        cur = ($urandom_range(0, 1) == 0) ? 16'h0008 : 16'h0400;
      end
      model_frame(cur, ev, eh, ec);
      run_frame(cur, ev, eh, ec, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
